// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data memory: access sizes, preload FSM states,
// sticky-error bit positions and the alignment rule.
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_e;

    localparam int ERR_MISALIGN_BIT = 0;
    localparam int ERR_OOB_BIT      = 1;

    // The reserved size code can never be aligned.
    function automatic logic size_misaligned(input logic [1:0] sz, input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (sz)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: byte enables and replicated store data for sub-word
// stores, and extraction plus sign/zero extension for sub-word loads.
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_lane,
    input  logic        i_ld_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata_rep,
    output logic [31:0] o_rdata_ext
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_be        = 4'b0000;
        o_wdata_rep = i_wdata;
        o_rdata_ext = 32'h0;
        w_byte      = 8'h0;
        w_half      = i_lane[1] ? i_rword[15:0] : i_rword[31:16];

        // Byte offset 0 lives in the most significant lane.
        case (i_lane)
            2'd0:    w_byte = i_rword[31:24];
            2'd1:    w_byte = i_rword[23:16];
            2'd2:    w_byte = i_rword[15:8];
            default: w_byte = i_rword[7:0];
        endcase

        case (i_size)
            SZ_BYTE: begin
                o_be        = 4'b1000 >> i_lane;
                o_wdata_rep = {4{i_wdata[7:0]}};
                o_rdata_ext = i_ld_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                o_be        = i_lane[1] ? 4'b0011 : 4'b1100;
                o_wdata_rep = {2{i_wdata[15:0]}};
                o_rdata_ext = i_ld_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            end
            SZ_WORD: begin
                o_be        = 4'b1111;
                o_rdata_ext = i_rword;
            end
            default: begin
                o_be        = 4'b0000;
                o_rdata_ext = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory for the single-cycle MIPS datapath: byte/half/word CPU port with
// alignment and range checks, plus a serial one-word-per-cycle preload engine.
//
// Preload handshake: a word transfers on a rising edge where load_valid and
// load_ready are both 1; load_ready is 1 for the whole LOAD state, load_valid=0
// simply stalls, and the word is never taken back once transferred.
module data_mem_ctrl
    import mips_mem_pkg::*;
#(
    parameter  int DEPTH = 512,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        load_start,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        load_done,
    output logic        busy,
    output logic        misalign,
    output logic        oob,
    output logic [1:0]  err_sticky,
    input  logic        err_clr,
    output state_e      dbg_state
);

    state_e             r_state;
    state_e             w_next_state;
    logic [IDX_W-1:0]   r_ptr;
    logic               r_done;
    logic [1:0]         r_err;
    logic [31:0]        r_mem [DEPTH];

    logic               w_access;
    logic               w_misalign;
    logic               w_oob;
    logic               w_beat;
    logic               w_beat_final;
    logic               w_busy;
    logic               w_store;
    logic [IDX_W-1:0]   w_idx;
    logic [31:0]        w_rword;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata_rep;
    logic [31:0]        w_rdata_ext;

    assign w_access   = mem_read | mem_write;
    assign w_misalign = w_access & size_misaligned(size, addr[1:0]);
    assign w_oob      = w_access & (addr[31:IDX_W+2] != '0);
    assign w_idx      = addr[IDX_W+1:2];
    assign w_rword    = r_mem[w_idx];
    assign w_store    = mem_write & ~w_busy & ~w_misalign & ~w_oob;

    mem_lane_align u_align (
        .i_size        (size),
        .i_lane        (addr[1:0]),
        .i_ld_unsigned (ld_unsigned),
        .i_wdata       (wdata),
        .i_rword       (w_rword),
        .o_be          (w_be),
        .o_wdata_rep   (w_wdata_rep),
        .o_rdata_ext   (w_rdata_ext)
    );

    always_comb begin
        w_next_state = r_state;
        w_beat       = 1'b0;
        w_beat_final = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load_start) w_next_state = ST_LOAD;
            end
            ST_LOAD: begin
                w_busy       = 1'b1;
                w_beat       = load_valid;
                // The last array slot ends the preload even without load_last.
                w_beat_final = load_valid & (load_last | (r_ptr == IDX_W'(DEPTH - 1)));
                if (w_beat_final) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_done  <= 1'b0;
            r_err   <= 2'b00;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_beat_final;
            if (r_state == ST_IDLE && load_start) r_ptr <= '0;
            else if (w_beat)                      r_ptr <= r_ptr + 1'b1;
            if (err_clr) begin
                r_err <= 2'b00;
            end else begin
                if (w_misalign) r_err[ERR_MISALIGN_BIT] <= 1'b1;
                if (w_oob)      r_err[ERR_OOB_BIT]      <= 1'b1;
            end
        end
    end

    // Array is deliberately not reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (w_beat) begin
            r_mem[r_ptr] <= load_data;
        end else if (w_store) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
            end
        end
    end

    assign rdata      = (mem_read & ~w_busy & ~w_misalign & ~w_oob) ? w_rdata_ext : 32'h0;
    assign load_ready = w_busy;
    assign busy       = w_busy;
    assign load_done  = r_done;
    assign misalign   = w_misalign;
    assign oob        = w_oob;
    assign err_sticky = r_err;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed preload/error scenarios followed
// by random CPU traffic checked against a big-endian byte-array reference model.
module tb_data_mem_ctrl;
    import mips_mem_pkg::*;

    localparam int DEPTH = 512;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        ld_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        load_start;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        load_done;
    logic        busy;
    logic        misalign;
    logic        oob;
    logic [1:0]  err_sticky;
    logic        err_clr;
    state_e      dbg_state;

    int          n_checks    = 0;
    int          n_errors    = 0;
    int          done_pulses = 0;
    logic [7:0]  exp_bytes [DEPTH*4];
    logic [31:0] pl_data   [DEPTH];
    logic [1:0]  exp_err;

    data_mem_ctrl #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .size        (size),
        .ld_unsigned (ld_unsigned),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .busy        (busy),
        .misalign    (misalign),
        .oob         (oob),
        .err_sticky  (err_sticky),
        .err_clr     (err_clr),
        .dbg_state   (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (load_done === 1'b1) done_pulses++;

    initial begin
        #2_000_000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_put_word(input int wi, input logic [31:0] w);
        exp_bytes[4*wi]   = w[31:24];
        exp_bytes[4*wi+1] = w[23:16];
        exp_bytes[4*wi+2] = w[15:8];
        exp_bytes[4*wi+3] = w[7:0];
    endtask

    // CPU access: combinational outputs checked mid-cycle, sticky errors after the edge.
    task automatic cpu(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input logic clr,
                       output logic [31:0] got);
        logic        exp_mis;
        logic        exp_oob;
        logic [31:0] exp_rd;
        int          ba;
        mem_read = rd; mem_write = wr; size = sz; ld_unsigned = uns;
        addr = a; wdata = wd; err_clr = clr;
        exp_mis = (rd || wr) && (sz == 2'b11 || (sz == SZ_HALF && a % 2 != 0) ||
                                 (sz == SZ_WORD && a % 4 != 0));
        exp_oob = (rd || wr) && ((a / 4) >= DEPTH);
        exp_rd  = 32'h0;
        ba      = int'(a % (DEPTH*4));
        if (rd && !exp_mis && !exp_oob) begin
            if (sz == SZ_BYTE)
                exp_rd = uns ? {24'h0, exp_bytes[ba]} : {{24{exp_bytes[ba][7]}}, exp_bytes[ba]};
            else if (sz == SZ_HALF)
                exp_rd = uns ? {16'h0, exp_bytes[ba], exp_bytes[ba+1]}
                             : {{16{exp_bytes[ba][7]}}, exp_bytes[ba], exp_bytes[ba+1]};
            else
                exp_rd = {exp_bytes[ba], exp_bytes[ba+1], exp_bytes[ba+2], exp_bytes[ba+3]};
        end
        @(negedge clk);
        got = rdata;
        check("rdata", rdata, exp_rd);
        check("misalign", 32'(misalign), 32'(exp_mis));
        check("oob", 32'(oob), 32'(exp_oob));
        @(posedge clk);
        if (wr && !exp_mis && !exp_oob) begin
            if (sz == SZ_BYTE) begin
                exp_bytes[ba] = wd[7:0];
            end else if (sz == SZ_HALF) begin
                exp_bytes[ba] = wd[15:8]; exp_bytes[ba+1] = wd[7:0];
            end else begin
                model_put_word(ba / 4, wd);
            end
        end
        if (clr) exp_err = 2'b00;
        else     exp_err = exp_err | {exp_oob, exp_mis};
        #1;
        mem_read = 1'b0; mem_write = 1'b0; err_clr = 1'b0;
        check("err_sticky", 32'(err_sticky), 32'(exp_err));
    endtask

    task automatic preload(input int n, input logic use_last, input int stall_pct);
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        check("load_ready", 32'(load_ready), 32'd1);
        check("busy_load", 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 99) < stall_pct) begin
                load_valid = 1'b0;
                @(posedge clk); #1;
            end
            load_valid = 1'b1;
            load_data  = pl_data[i];
            load_last  = use_last && (i == n - 1);
            @(posedge clk); #1;
            model_put_word(i, pl_data[i]);
        end
        load_valid = 1'b0; load_last = 1'b0;
        check("load_done", 32'(load_done), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
        check("state_after", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge clk); #1;
        check("load_done_pulse", 32'(load_done), 32'd0);
    endtask

    initial begin
        logic [31:0] got;
        logic [1:0]  sz;
        logic [1:0]  lane;
        logic [31:0] a;
        int          op;

        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; size = 2'b00; ld_unsigned = 1'b0;
        addr = 32'h0; wdata = 32'h0; load_start = 1'b0; load_valid = 1'b0;
        load_data = 32'h0; load_last = 1'b0; err_clr = 1'b0; exp_err = 2'b00;

        repeat (3) @(posedge clk);
        #1;
        check("rst_load_ready", 32'(load_ready), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err_sticky), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full-depth preload, terminated by the pointer reaching the end.
        for (int i = 0; i < DEPTH; i++) pl_data[i] = 32'(i * 4);
        preload(DEPTH, 1'b0, 20);
        cpu(1, 0, SZ_WORD, 0, 32'h7FC, 32'h0, 0, got);
        check("word_7fc", got, 32'h0000_07FC);

        // Short preload ended by load_last; word 3 keeps its earlier value.
        pl_data[0] = 32'h1122_3344; pl_data[1] = 32'hAABB_CCDD; pl_data[2] = 32'h8000_0001;
        preload(3, 1'b1, 0);
        cpu(1, 0, SZ_WORD, 0, 32'hC, 32'h0, 0, got);
        check("word3_kept", got, 32'h0000_000C);
        cpu(1, 0, SZ_WORD, 0, 32'h8, 32'h0, 0, got);
        check("word2_pl", got, 32'h8000_0001);

        // Sub-word stores and extending loads.
        cpu(0, 1, SZ_BYTE, 0, 32'h2, 32'h1234_56EE, 0, got);
        cpu(1, 0, SZ_WORD, 0, 32'h0, 32'h0, 0, got);
        check("byte_store", got, 32'h1122_EE44);
        cpu(1, 0, SZ_BYTE, 0, 32'h4, 32'h0, 0, got);
        check("lb_signed", got, 32'hFFFF_FFAA);
        cpu(1, 0, SZ_BYTE, 1, 32'h4, 32'h0, 0, got);
        check("lb_unsigned", got, 32'h0000_00AA);
        cpu(1, 0, SZ_HALF, 0, 32'h6, 32'h0, 0, got);
        check("lh_signed", got, 32'hFFFF_CCDD);
        cpu(1, 1, SZ_HALF, 1, 32'h2, 32'hABCD_5A5A, 0, got);
        check("rw_same_old", got, 32'h0000_EE44);
        cpu(1, 0, SZ_WORD, 0, 32'h0, 32'h0, 0, got);
        check("rw_same_new", got, 32'h1122_5A5A);

        // Misaligned and out-of-range stores are suppressed and recorded.
        cpu(0, 1, SZ_WORD, 0, 32'h6, 32'hFFFF_FFFF, 0, got);
        check("err_mis", 32'(err_sticky), 32'h1);
        cpu(1, 0, SZ_WORD, 0, 32'h4, 32'h0, 0, got);
        check("mis_suppressed", got, 32'hAABB_CCDD);
        cpu(1, 1, SZ_WORD, 0, 32'h800, 32'h5555_5555, 0, got);
        check("oob_rdata", got, 32'h0);
        check("err_both", 32'(err_sticky), 32'h3);
        cpu(0, 0, SZ_WORD, 0, 32'h0, 32'h0, 1, got);
        check("err_clr", 32'(err_sticky), 32'h0);
        cpu(1, 0, SZ_WORD, 0, 32'h0, 32'h0, 0, got);
        check("oob_suppressed", got, 32'h1122_5A5A);

        // CPU access during LOAD is blocked; reset mid-LOAD keeps written words.
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        mem_write = 1'b1; mem_read = 1'b1; size = SZ_WORD; addr = 32'h0; wdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 10; i++) begin
            load_valid = 1'b1;
            load_data  = 32'hCAFE_0000 + 32'(i);
            @(negedge clk);
            check("rdata_in_load", rdata, 32'h0);
            @(posedge clk); #1;
            model_put_word(i, 32'hCAFE_0000 + 32'(i));
        end
        rst_n = 1'b0;
        #2;
        check("rst_mid_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_mid_busy", 32'(busy), 32'd0);
        load_valid = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_done", 32'(load_done), 32'd0);
        rst_n = 1'b1;
        exp_err = 2'b00;
        repeat (2) begin
            @(posedge clk); #1;
            check("no_done_after_rst", 32'(load_done), 32'd0);
        end
        for (int i = 0; i < 10; i++) cpu(1, 0, SZ_WORD, 0, 32'(i * 4), 32'h0, 0, got);
        cpu(1, 0, SZ_WORD, 0, 32'h0, 32'h0, 0, got);
        check("w_in_load_ignored", got, 32'hCAFE_0000);

        // Random CPU traffic against the byte-array model.
        for (int k = 0; k < 400; k++) begin
            op = $urandom_range(0, 3);
            sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            lane = 2'($urandom_range(0, 3));
            if (sz == SZ_HALF && $urandom_range(0, 3) != 0) lane[0] = 1'b0;
            if (sz == SZ_WORD && $urandom_range(0, 3) != 0) lane = 2'b00;
            a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'(lane);
            if ($urandom_range(0, 7) == 0) a[11 + $urandom_range(0, 20)] = 1'b1;
            cpu(op == 0 || op == 2, op == 1 || op == 2, sz, 1'($urandom_range(0, 1)), a,
                $urandom, $urandom_range(0, 15) == 0, got);
        end

        check("done_pulses", 32'(done_pulses), 32'd2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised data memory for the single-cycle MIPS datapath, with a serial preload engine that streams one word per cycle instead of a wide load bus. CPU port supports byte, halfword and word stores, sign- or zero-extended loads, and big-endian byte lanes. Alignment and range violations are flagged, and the offending stores are suppressed. Sits between ALU result / rt operand and the writeback mux; preload is driven by the testbench or boot loader.

Parameters:
DEPTH, 512, number of 32-bit words; power of two, minimum 4.
IDX_W, $clog2(DEPTH), word index width (derived, not overridden).

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
mem_read  in  1  CPU load enable
mem_write  in  1  CPU store enable
size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as misaligned)
ld_unsigned  in  1  1 = zero-extend sub-word loads, 0 = sign-extend
addr  in  32  byte address
wdata  in  32  store data; sub-word stores use the low bits
rdata  out  32  load data (combinational)
load_start  in  1  begin preload (sampled in IDLE only)
load_valid  in  1  load_data valid
load_data  in  32  preload word
load_last  in  1  qualifies the final preload word
load_ready  out  1  engine accepts a word this cycle
load_done  out  1  one-cycle pulse after the final preload word is written
busy  out  1  preload in progress
misalign  out  1  combinational: current CPU access is misaligned
oob  out  1  combinational: addr[31:2] >= DEPTH
err_sticky  out  2  {oob_seen, misalign_seen}
err_clr  in  1  clears err_sticky

Behaviour:
- Reset (rst_n=0): FSM=IDLE, ptr=0, load_ready=0, load_done=0, busy=0, err_sticky=0. Memory array is not reset; contents survive a reset.
- FSM IDLE:
  - load_start=1 -> LOAD, ptr=0.
- FSM LOAD:
  - busy=1, load_ready=1.
  - Each cycle with load_valid=1 writes mem[ptr]=load_data and increments ptr.
  - If load_last=1 or ptr==DEPTH-1 on that beat -> IDLE next cycle, and load_done=1 for exactly that next cycle.
  - load_valid=0 stalls the engine; ptr holds.
  - load_start is ignored while in LOAD.
- Reset mid-LOAD: FSM -> IDLE, no load_done; words already written remain.
- CPU port during LOAD: mem_write is ignored, and rdata=0 regardless of mem_read.
- Word index = addr[IDX_W+1:2]. Byte lane = addr[1:0], big-endian: offset 0 is bits [31:24].
- Alignment rules:
  - Half needs addr[0]=0; word needs addr[1:0]=00.
  - size=11 is always misaligned.
  - misalign is asserted only when mem_read or mem_write is 1.
- oob is asserted when (mem_read or mem_write) and addr[31:IDX_W+2] != 0.
- Stores:
  - Performed at the rising edge when mem_write=1, not busy, no misalign, no oob.
  - Only the selected bytes are written (byte-enable read-modify-write within the word); other lanes are unchanged.
  - Byte stores write wdata[7:0]; half stores write wdata[15:0].
- Loads:
  - rdata=0 when mem_read=0, on misalign, or on oob (never high-Z).
  - Otherwise: word -> mem word; half -> selected 16 bits, extended; byte -> selected 8 bits, extended.
- err_sticky:
  - Bit 0 is set on any cycle with misalign=1; bit 1 is set on any cycle with oob=1.
  - err_clr has priority over a same-cycle set.
- Simultaneous mem_read and mem_write to the same address: rdata shows the old data; the new data is visible from the next cycle.

Decomposition:
- Shared package mips_mem_pkg:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - FSM state enum {ST_IDLE, ST_LOAD};
  - error bit positions.
- One natural sub-module, mem_lane_align: purely combinational byte-enable generation, store-data lane replication, and load extract/extend. The FSM and the array stay in data_mem_ctrl.

Test Plan:
- Preload 512 words of index*4, no load_last -> load_done pulses once, 1 cycle after beat 512; read addr 0x7FC word returns 0x000007FC; busy=0 afterwards.
- Preload 3 words 0x11223344, 0xAABBCCDD, 0x80000001 with load_last on beat 3 -> load_done next cycle; word 3 keeps its pre-preload value.
- Word 0x11223344 at addr 0; byte store 0xEE to addr 2 -> word reads 0x1122EE44; signed byte load at addr 0x4 (0xAA) -> 0xFFFFFFAA; unsigned -> 0x000000AA; signed half at addr 0x6 -> 0xFFFFCCDD.
- Word store to addr 0x6 -> misalign=1, memory unchanged, err_sticky=01; store to addr 0x800 -> oob=1, rdata=0, err_sticky=11; err_clr -> 00.
- Assert rst_n=0 after 10 preload beats -> FSM IDLE, no load_done, words 0-9 retain preload data.
- mem_write during LOAD to addr 0 -> ignored, mem[0] holds preload value; mem_read during LOAD -> rdata=0.
